alu_result_collector: RTL and testbench



---
 rtl/alu_result_collector.sv | 99 +++++++++
 tb/tb_alu_result_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_collector.sv
// alu_result_collector: tags ALU ops through a latency-matched delay line, queues results in a FIFO, credit-gates issue (ALU_COLLECT_ZERO_RECALC_EN recomputes the zero flag)
module alu_result_collector #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [TAG_W-1:0]           issue_tag,
  output logic                       issue_ready,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_carry,
  input  logic                       alu_zero,
  input  logic                       alu_ovf,
  input  logic                       alu_sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [3:0]                 out_flags,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(LAT+1)-1:0]   in_flight,
  output logic                       overrun_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  logic [LAT:0]       dv;
  logic [TAG_W-1:0]   dt [LAT+1];
  logic [WIDTH-1:0]   mem_res [DEPTH];
  logic [3:0]         mem_fl [DEPTH];
  logic [TAG_W-1:0]   mem_tag [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic               accept, wr, pop, head_new, zero_f;
  logic [3:0]         cap_flags;
`ifdef ALU_COLLECT_ZERO_RECALC_EN
  assign zero_f = alu_result == '0;
`else
  assign zero_f = alu_zero;
`endif
  assign cap_flags   = {alu_carry, zero_f, alu_ovf, alu_sign};
  assign issue_ready = 32'(count) + 32'(in_flight) < DEPTH;
  assign accept      = issue_valid & issue_ready;
  assign wr          = dv[LAT];
  assign pop         = out_valid & out_ready;
  assign rd_nxt      = rd_ptr + AW'(pop);
  assign count_nxt   = count + CW'(wr) - CW'(pop);
  assign head_new    = wr && wr_ptr == rd_nxt;
  // ops still travelling toward capture, including the one being captured next edge
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= LAT; i++) in_flight = in_flight + IW'(dv[i]);
  end
  // valid+tag line: the oldest stage lines up with the cycle the ALU result is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      dv <= '0;
      for (int i = 0; i <= LAT; i++) dt[i] <= '0;
    end else begin
      dv    <= {dv[LAT-1:0], accept};
      dt[0] <= issue_tag;
      for (int i = 1; i <= LAT; i++) dt[i] <= dt[i-1];
    end
  end
  // FIFO storage; credit guarantees the tail slot is free whenever a capture arrives
  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      mem_res[wr_ptr] <= alu_result;
      mem_fl[wr_ptr]  <= cap_flags;
      mem_tag[wr_ptr] <= dt[LAT];
    end
  end
  // pointers, count, registered head (holds last values once drained) and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      out_tag     <= '0;
      overrun_err <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(wr);
      rd_ptr      <= rd_nxt;
      count       <= count_nxt;
      out_valid   <= count_nxt != '0;
      overrun_err <= overrun_err | (issue_valid & ~issue_ready);
      if (count_nxt != '0) begin
        out_result <= head_new ? alu_result : mem_res[rd_nxt];
        out_flags  <= head_new ? cap_flags  : mem_fl[rd_nxt];
        out_tag    <= head_new ? dt[LAT]    : mem_tag[rd_nxt];
      end
    end
  end
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: vector table, corner sequences and a random stream against a queue-based model
module tb_alu_result_collector;
  localparam int DEPTH = 4;
  localparam int LAT = 2;
`ifdef ALU_COLLECT_ZERO_RECALC_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  typedef struct {logic [63:0] res; logic c, z, o, s;} alu_t;
  typedef struct {logic [3:0] tag; logic [63:0] res; logic [3:0] fl; int e;} ent_t;
  typedef struct {logic [3:0] tag; alu_t a; logic [3:0] fl;} vec_t;
  logic clk = 0, rst = 1, issue_valid = 0, issue_ready, out_valid, out_ready = 0;
  logic alu_carry = 0, alu_zero = 0, alu_ovf = 0, alu_sign = 0, overrun_err;
  logic [3:0] issue_tag = 0, out_flags, out_tag;
  logic [63:0] alu_result = 0, out_result;
  logic [1:0] in_flight;
  int errs = 0, checks = 0, cyc = 0, npop = 0;
  bit m_ovr = 0;
  ent_t q[$];
  ent_t m_last = '{default: 0};
  alu_t sched[int];
  alu_t nxt;
  vec_t tbl [5];

  alu_result_collector dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_sign(alu_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .out_tag(out_tag), .in_flight(in_flight), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_fl(alu_t a);
    return {a.c, ZR ? (a.res == 64'd0) : a.z, a.o, a.s};
  endfunction

  function automatic alu_t rnd_alu();
    alu_t a;
    a.res = {$urandom, $urandom};
    a.c = 1'($urandom); a.z = 1'($urandom); a.o = 1'($urandom); a.s = 1'($urandom);
    return a;
  endfunction

  // an op accepted at edge e lands in the FIFO at edge e+LAT+1
  function automatic bit m_valid();
    return q.size() > 0 && q[0].e + LAT + 1 <= cyc;
  endfunction

  function automatic int m_infl();
    int n = 0;
    foreach (q[i]) if (q[i].e + LAT + 1 > cyc) n++;
    return n;
  endfunction

  task automatic tick();
    bit r, acc, pop;
    ent_t en;
    alu_t a;
    logic [3:0] tg;
    r = rst;
    tg = issue_tag;
    acc = !r && issue_valid && q.size() < DEPTH;
    pop = !r && out_ready && m_valid();
    if (!r && issue_valid && q.size() >= DEPTH) m_ovr = 1;
    @(posedge clk);
    cyc++;
    #1;
    if (r) begin
      q.delete();
      m_ovr = 0;
      m_last = '{default: 0};
    end
    if (pop) begin
      void'(q.pop_front());
      npop++;
    end
    if (acc) begin
      en.tag = tg; en.res = nxt.res; en.fl = exp_fl(nxt); en.e = cyc;
      q.push_back(en);
      sched[cyc + LAT] = nxt;
    end
    if (m_valid()) m_last = q[0];
    if (sched.exists(cyc)) begin
      a = sched[cyc];
      sched.delete(cyc);
    end else a = rnd_alu();
    alu_result = a.res; alu_carry = a.c; alu_zero = a.z; alu_ovf = a.o; alu_sign = a.s;
    chk("out_valid", out_valid, m_valid());
    chk("out_result", out_result, m_last.res);
    chk("out_flags", out_flags, m_last.fl);
    chk("out_tag", out_tag, m_last.tag);
    chk("issue_ready", issue_ready, q.size() < DEPTH);
    chk("in_flight", in_flight, m_infl());
    chk("overrun_err", overrun_err, m_ovr);
  endtask

  task automatic do_reset();
    rst = 1; issue_valid = 0; out_ready = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    int issued, base;
    tbl[0] = '{4'd3, '{64'h5, 1'b1, 1'b0, 1'b0, 1'b0}, 4'b1000};
    tbl[1] = '{4'd1, '{64'h0, 1'b0, 1'b0, 1'b0, 1'b0}, {1'b0, ZR, 2'b00}};
    tbl[2] = '{4'd2, '{64'h0, 1'b0, 1'b1, 1'b0, 1'b0}, 4'b0100};
    tbl[3] = '{4'd5, '{64'h7, 1'b0, 1'b1, 1'b0, 1'b0}, {1'b0, !ZR, 2'b00}};
    tbl[4] = '{4'd9, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1}, 4'b1011};
    nxt = rnd_alu();
    do_reset();
    chk("rst_ready", issue_ready, 1);
    chk("rst_valid", out_valid, 0);
    foreach (tbl[k]) begin
      nxt = tbl[k].a; issue_tag = tbl[k].tag; issue_valid = 1;
      tick();
      issue_valid = 0;
      repeat (LAT) tick();
      chk("tbl_not_yet", out_valid, 0);
      tick();
      chk("tbl_valid", out_valid, 1);
      chk("tbl_flags", out_flags, tbl[k].fl);
      chk("tbl_result", out_result, tbl[k].a.res);
      chk("tbl_tag", out_tag, tbl[k].tag);
      out_ready = 1;
      tick();
      out_ready = 0;
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_tag = 4'(i); nxt = rnd_alu();
      tick();
    end
    chk("b2b_ready_low", issue_ready, 0);
    issue_tag = 4'd4;
    tick();
    issue_valid = 0;
    chk("b2b_overrun", overrun_err, 1);
    repeat (4) tick();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_order", out_tag, 64'(i));
      tick();
    end
    chk("b2b_no_fifth", out_valid, 0);
    out_ready = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_tag = 4'(8 + i); nxt = rnd_alu();
      tick();
    end
    issue_valid = 0;
    repeat (13) tick();
    chk("bp_ready_full", issue_ready, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("bp_one_pop", out_tag, 64'd9);
    chk("bp_ready_freed", issue_ready, 1);
    do_reset();
    issue_valid = 1; issue_tag = 4'hA; nxt = rnd_alu();
    tick();
    issue_tag = 4'hB; nxt = rnd_alu();
    tick();
    issue_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("mid_valid", out_valid, 0);
    chk("mid_inflight", in_flight, 0);
    chk("mid_ready", issue_ready, 1);
    out_ready = 1;
    repeat (5) begin
      tick();
      chk("mid_no_entry", out_valid, 0);
    end
    do_reset();
    base = npop;
    issued = 0;
    for (int c = 0; c < 3000 && npop - base < 100; c++) begin
      issue_valid = issued < 100 && q.size() < DEPTH && $urandom_range(0, 9) < 7;
      issue_tag = 4'(issued);
      nxt = rnd_alu();
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (issue_valid) issued++;
    end
    issue_valid = 0;
    chk("stream_received", 64'(npop - base), 64'd100);
    chk("stream_overrun", overrun_err, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
